// File: rtl/test_result_monitor.sv
// Test-result monitor: watches CPU memory writes against NCHK expected (addr, data) entries
// and reports pass / fail / timeout. Define MON_FAILCAP_EN to add first-strict-mismatch capture ports.
module test_result_monitor #(
   parameter  int ADDR_W = 16,
   parameter  int DATA_W = 8,
   parameter  int NCHK   = 4,
   parameter  int TMO_W  = 16,
   localparam int IDX_W  = (NCHK > 1) ? $clog2(NCHK) : 1
) (
   input  logic              ph1,
   input  logic              resetb,
   input  logic              start,
   input  logic [TMO_W-1:0]  timeout_cycles,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_valid,
   input  logic              cfg_strict,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_wdata,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timed_out,
   output logic [NCHK-1:0]   match_mask
`ifdef MON_FAILCAP_EN
   ,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
`endif
);

   typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TMO} state_t;

   state_t            state_q, state_d;
   logic [NCHK-1:0]   valid_q, valid_d, strict_q, strict_d;
   logic [NCHK-1:0]   written_q, written_d, match_q, match_d;
   logic [ADDR_W-1:0] addr_q [NCHK];
   logic [ADDR_W-1:0] addr_d [NCHK];
   logic [DATA_W-1:0] data_q [NCHK];
   logic [DATA_W-1:0] data_d [NCHK];
   logic [TMO_W-1:0]  cnt_q, cnt_d;

   logic [NCHK-1:0]   hit, eq, mis, upd_written, upd_match;
   logic              all_ok, tmo_hit, cfg_ok;

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      strict_d  = strict_q;
      addr_d    = addr_q;
      data_d    = data_q;
      written_d = written_q;
      match_d   = match_q;
      cnt_d     = cnt_q;
      hit       = '0;
      eq        = '0;
      for (int unsigned i = 0; i < NCHK; i++) begin
         hit[i] = valid_q[i] & bus_we & (bus_addr == addr_q[i]);
         eq[i]  = (bus_wdata == data_q[i]);
      end
      // completion is judged on the post-write view so PASS lands on the same edge as the write
      upd_written = written_q | hit;
      upd_match   = (match_q & ~hit) | (hit & eq);
      mis         = hit & strict_q & ~eq;
      all_ok      = &(~valid_q | (upd_written & upd_match));
      tmo_hit     = (timeout_cycles != '0) && (cnt_q == timeout_cycles - TMO_W'(1));
      cfg_ok      = cfg_we && (state_q != RUN) && ({1'b0, cfg_idx} < (IDX_W+1)'(NCHK));

      if (state_q == RUN) begin
         written_d = upd_written;
         match_d   = upd_match;
         if (cnt_q != '1) cnt_d = cnt_q + TMO_W'(1);
         if (|mis)         state_d = FAIL;
         else if (all_ok)  state_d = PASS;
         else if (tmo_hit) state_d = TMO;
      end else if (start) begin
         state_d   = RUN;
         written_d = '0;
         match_d   = '0;
         cnt_d     = '0;
      end

      if (cfg_ok) begin
         valid_d[cfg_idx]  = cfg_valid;
         strict_d[cfg_idx] = cfg_strict;
         addr_d[cfg_idx]   = cfg_addr;
         data_d[cfg_idx]   = cfg_data;
      end
   end

   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         state_q   <= IDLE;
         valid_q   <= '0;
         strict_q  <= '0;
         addr_q    <= '{default: '0};
         data_q    <= '{default: '0};
         written_q <= '0;
         match_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         strict_q  <= strict_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         written_q <= written_d;
         match_q   <= match_d;
         cnt_q     <= cnt_d;
      end
   end

   assign done       = (state_q == PASS) || (state_q == FAIL) || (state_q == TMO);
   assign pass       = (state_q == PASS);
   assign fail       = (state_q == FAIL);
   assign timed_out  = (state_q == TMO);
   assign match_mask = match_q;

`ifdef MON_FAILCAP_EN
   logic [IDX_W-1:0]  fidx_q, fidx_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [DATA_W-1:0] fdata_q, fdata_d;
   logic              found;

   // any strict mismatch ends RUN, so the first one seen is the only one captured
   always_comb begin
      fidx_d  = fidx_q;
      faddr_d = faddr_q;
      fdata_d = fdata_q;
      found   = 1'b0;
      if (state_q == RUN) begin
         if (|mis) begin
            faddr_d = bus_addr;
            fdata_d = bus_wdata;
            for (int unsigned i = 0; i < NCHK; i++) begin
               if (mis[i] && !found) begin
                  fidx_d = IDX_W'(i);
                  found  = 1'b1;
               end
            end
         end
      end else if (start) begin
         fidx_d  = '0;
         faddr_d = '0;
         fdata_d = '0;
      end
   end

   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         fidx_q  <= '0;
         faddr_q <= '0;
         fdata_q <= '0;
      end else begin
         fidx_q  <= fidx_d;
         faddr_q <= faddr_d;
         fdata_q <= fdata_d;
      end
   end

   assign fail_idx  = fidx_q;
   assign fail_addr = faddr_q;
   assign fail_data = fdata_q;
`endif

endmodule

// File: tb/tb_test_result_monitor.sv
// Self-checking bench for test_result_monitor: directed scenarios plus randomized episodes
// checked against a behavioural model of the monitor rules.
module tb_test_result_monitor;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int NCHK   = 4;
   localparam int TMO_W  = 16;
   localparam int IDX_W  = 2;

   logic              ph1 = 1'b0;
   logic              resetb = 1'b0;
   logic              start = 1'b0;
   logic [TMO_W-1:0]  timeout_cycles = '0;
   logic              cfg_we = 1'b0;
   logic [IDX_W-1:0]  cfg_idx = '0;
   logic              cfg_valid = 1'b0;
   logic              cfg_strict = 1'b0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [DATA_W-1:0] cfg_data = '0;
   logic              bus_we = 1'b0;
   logic [ADDR_W-1:0] bus_addr = '0;
   logic [DATA_W-1:0] bus_wdata = '0;
   logic              done, pass, fail, timed_out;
   logic [NCHK-1:0]   match_mask;
`ifdef MON_FAILCAP_EN
   logic [IDX_W-1:0]  fail_idx;
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_data;
`endif

   int checks = 0;
   int failures = 0;

   always #5 ph1 = ~ph1;

   test_result_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCHK(NCHK), .TMO_W(TMO_W)) dut (
      .ph1(ph1), .resetb(resetb), .start(start), .timeout_cycles(timeout_cycles),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_strict(cfg_strict),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .done(done), .pass(pass), .fail(fail), .timed_out(timed_out), .match_mask(match_mask)
`ifdef MON_FAILCAP_EN
      , .fail_idx(fail_idx), .fail_addr(fail_addr), .fail_data(fail_data)
`endif
   );

   // Reference model: phase 0 idle, 1 running, 2 passed, 3 failed, 4 timed out
   int          m_phase;
   bit          mv [NCHK];
   bit          ms [NCHK];
   bit          mw [NCHK];
   bit          mm [NCHK];
   int unsigned ma [NCHK];
   int unsigned md [NCHK];
   int unsigned m_elapsed;
   int unsigned m_fidx, m_faddr, m_fdata;

   task automatic model_reset();
      m_phase = 0;
      m_elapsed = 0;
      m_fidx = 0; m_faddr = 0; m_fdata = 0;
      for (int c = 0; c < NCHK; c++) begin
         mv[c] = 0; ms[c] = 0; mw[c] = 0; mm[c] = 0; ma[c] = 0; md[c] = 0;
      end
   endtask

   task automatic model_step();
      bit bad;
      bit all_ok;
      bad = 0;
      all_ok = 1;
      if (m_phase == 1) begin
         for (int c = 0; c < NCHK; c++) begin
            if (mv[c] && bus_we && bus_addr == ma[c]) begin
               mw[c] = 1;
               mm[c] = (bus_wdata == md[c]);
               if (ms[c] && !mm[c] && !bad) begin
                  bad = 1; m_fidx = c; m_faddr = bus_addr; m_fdata = bus_wdata;
               end
            end
         end
         for (int c = 0; c < NCHK; c++)
            if (mv[c] && !(mw[c] && mm[c])) all_ok = 0;
         m_elapsed++;
         if (bad) m_phase = 3;
         else if (all_ok) m_phase = 2;
         else if (timeout_cycles != 0 && m_elapsed == timeout_cycles) m_phase = 4;
      end else begin
         if (cfg_we && cfg_idx < NCHK) begin
            mv[cfg_idx] = cfg_valid; ms[cfg_idx] = cfg_strict;
            ma[cfg_idx] = cfg_addr;  md[cfg_idx] = cfg_data;
         end
         if (start) begin
            m_phase = 1;
            m_elapsed = 0;
            m_fidx = 0; m_faddr = 0; m_fdata = 0;
            for (int c = 0; c < NCHK; c++) begin mw[c] = 0; mm[c] = 0; end
         end
      end
   endtask

   function automatic logic [7:0] exp_vec();
      logic [3:0] mk;
      for (int c = 0; c < NCHK; c++) mk[c] = mm[c];
      return {m_phase >= 2, m_phase == 2, m_phase == 3, m_phase == 4, mk};
   endfunction

   task automatic step();
      model_step();
      @(posedge ph1);
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic cfg(input int unsigned idx, input bit v, input bit s,
                      input int unsigned a, input int unsigned d);
      cfg_we = 1'b1; cfg_idx = idx[IDX_W-1:0]; cfg_valid = v; cfg_strict = s;
      cfg_addr = a[ADDR_W-1:0]; cfg_data = d[DATA_W-1:0];
      step();
      cfg_we = 1'b0;
   endtask

   task automatic bus_write(input int unsigned a, input int unsigned d);
      bus_we = 1'b1; bus_addr = a[ADDR_W-1:0]; bus_wdata = d[DATA_W-1:0];
      step();
      bus_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      model_reset();
      @(posedge ph1);
      #1;
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'h00) begin
         failures++; $display("FAIL reset_state got=%b exp=%b", obs, 8'h00);
      end
      resetb = 1'b1;
      bus_write('h40, 'h42);
      steps(3);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'h00) begin
         failures++; $display("FAIL idle_without_start got=%b exp=%b", obs, 8'h00);
      end
   endtask

   task automatic test_basic_pass();
      logic [7:0] obs;
      cfg(0, 1, 0, 'h40, 'h42);
      timeout_cycles = 16'd60;
      pulse_start();
      steps(9);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b0000_0000) begin
         failures++; $display("FAIL basic_before_write got=%b exp=%b", obs, 8'b0000_0000);
      end
      bus_write('h40, 'h42);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1100_0001) begin
         failures++; $display("FAIL basic_pass got=%b exp=%b", obs, 8'b1100_0001);
      end
      bus_write('h40, 'h00);
      steps(3);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1100_0001) begin
         failures++; $display("FAIL pass_hold got=%b exp=%b", obs, 8'b1100_0001);
      end
   endtask

   task automatic test_latest_write();
      logic [7:0] obs;
      pulse_start();
      bus_write('h40, 'h41);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b0000_0000) begin
         failures++; $display("FAIL nonstrict_mismatch got=%b exp=%b", obs, 8'b0000_0000);
      end
      bus_write('h40, 'h42);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1100_0001) begin
         failures++; $display("FAIL nonstrict_then_match got=%b exp=%b", obs, 8'b1100_0001);
      end
   endtask

   task automatic test_strict();
      logic [7:0] obs;
      cfg(0, 1, 1, 'h40, 'h42);
      pulse_start();
      bus_write('h40, 'h41);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1010_0000) begin
         failures++; $display("FAIL strict_fail got=%b exp=%b", obs, 8'b1010_0000);
      end
`ifdef MON_FAILCAP_EN
      checks++;
      if ({fail_idx, fail_addr, fail_data} !== {2'd0, 16'h0040, 8'h41}) begin
         failures++;
         $display("FAIL strict_capture got=%h/%h/%h exp=0/0040/41", fail_idx, fail_addr, fail_data);
      end
`endif
      bus_write('h40, 'h42);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1010_0000) begin
         failures++; $display("FAIL fail_hold got=%b exp=%b", obs, 8'b1010_0000);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] obs;
      cfg(0, 1, 0, 'h40, 'h42);
      cfg(1, 1, 0, 'h80, 'h55);
      timeout_cycles = 16'd20;
      pulse_start();
      steps(2);
      bus_write('h40, 'h42);
      steps(16);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b0000_0001) begin
         failures++; $display("FAIL timeout_early got=%b exp=%b", obs, 8'b0000_0001);
      end
      step();
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1001_0001) begin
         failures++; $display("FAIL timeout_at_20 got=%b exp=%b", obs, 8'b1001_0001);
      end
   endtask

   task automatic test_timeout_boundary();
      logic [7:0] obs;
      pulse_start();
      steps(2);
      bus_write('h40, 'h42);
      steps(16);
      bus_write('h80, 'h55);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1100_0011) begin
         failures++; $display("FAIL pass_over_tmo got=%b exp=%b", obs, 8'b1100_0011);
      end
      cfg(1, 1, 1, 'h40, 'h99);
      pulse_start();
      steps(19);
      bus_write('h40, 'h42);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1010_0001) begin
         failures++; $display("FAIL fail_over_pass_tmo got=%b exp=%b", obs, 8'b1010_0001);
      end
`ifdef MON_FAILCAP_EN
      checks++;
      if ({fail_idx, fail_addr, fail_data} !== {2'd1, 16'h0040, 8'h42}) begin
         failures++;
         $display("FAIL boundary_capture got=%h/%h/%h exp=1/0040/42", fail_idx, fail_addr, fail_data);
      end
`endif
   endtask

   task automatic test_zero_valid();
      logic [7:0] obs;
      for (int c = 0; c < NCHK; c++) cfg(c, 0, 0, 0, 0);
      timeout_cycles = 16'd1;
      pulse_start();
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b0000_0000) begin
         failures++; $display("FAIL zero_valid_run got=%b exp=%b", obs, 8'b0000_0000);
      end
      step();
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1100_0000) begin
         failures++; $display("FAIL zero_valid_pass got=%b exp=%b", obs, 8'b1100_0000);
      end
   endtask

   task automatic test_cfg_in_run();
      logic [7:0] obs;
      cfg(0, 1, 0, 'h40, 'h42);
      timeout_cycles = 16'd0;
      pulse_start();
      cfg(0, 1, 0, 'h40, 'h77);
      steps(30);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b0000_0000) begin
         failures++; $display("FAIL no_timeout_when_zero got=%b exp=%b", obs, 8'b0000_0000);
      end
      bus_write('h40, 'h42);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1100_0001) begin
         failures++; $display("FAIL cfg_ignored_in_run got=%b exp=%b", obs, 8'b1100_0001);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] obs;
      cfg(1, 1, 0, 'h80, 'h55);
      pulse_start();
      bus_write('h40, 'h42);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b0000_0001) begin
         failures++; $display("FAIL partial_match got=%b exp=%b", obs, 8'b0000_0001);
      end
      #2 resetb = 1'b0;
      #1;
      model_reset();
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'h00) begin
         failures++; $display("FAIL async_reset got=%b exp=%b", obs, 8'h00);
      end
      @(posedge ph1);
      #1 resetb = 1'b1;
      bus_write('h40, 'h42);
      steps(2);
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'h00) begin
         failures++; $display("FAIL post_reset_idle got=%b exp=%b", obs, 8'h00);
      end
      pulse_start();
      step();
      obs = {done, pass, fail, timed_out, match_mask};
      checks++;
      if (obs !== 8'b1100_0000) begin
         failures++; $display("FAIL channels_cleared got=%b exp=%b", obs, 8'b1100_0000);
      end
   endtask

   task automatic test_random();
      logic [7:0] obs;
      logic [7:0] exp;
      for (int ep = 0; ep < 10; ep++) begin
         for (int c = 0; c < NCHK; c++)
            cfg(c, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                'h10 * $urandom_range(1, 3), $urandom_range(0, 1));
         timeout_cycles = TMO_W'($urandom_range(0, 30));
         pulse_start();
         for (int cyc = 0; cyc < 40; cyc++) begin
            bus_we    = $urandom_range(0, 2) != 0;
            bus_addr  = ADDR_W'('h10 * $urandom_range(1, 4));
            bus_wdata = DATA_W'($urandom_range(0, 1));
            start     = $urandom_range(0, 24) == 0;
            cfg_we    = $urandom_range(0, 9) == 0;
            cfg_idx   = IDX_W'($urandom_range(0, NCHK - 1));
            cfg_valid = $urandom_range(0, 1) == 1;
            cfg_strict = $urandom_range(0, 1) == 1;
            cfg_addr  = ADDR_W'('h10 * $urandom_range(1, 3));
            cfg_data  = DATA_W'($urandom_range(0, 1));
            step();
            bus_we = 1'b0; start = 1'b0; cfg_we = 1'b0;
            obs = {done, pass, fail, timed_out, match_mask};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
               failures++; $display("FAIL random ep=%0d cyc=%0d got=%b exp=%b", ep, cyc, obs, exp);
            end
`ifdef MON_FAILCAP_EN
            checks++;
            if ({fail_idx, fail_addr, fail_data} !==
                {IDX_W'(m_fidx), ADDR_W'(m_faddr), DATA_W'(m_fdata)}) begin
               failures++;
               $display("FAIL random_capture ep=%0d cyc=%0d got=%h/%h/%h exp=%h/%h/%h", ep, cyc,
                        fail_idx, fail_addr, fail_data, m_fidx, m_faddr, m_fdata);
            end
`endif
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_pass();
      test_latest_write();
      test_strict();
      test_timeout();
      test_timeout_boundary();
      test_zero_valid();
      test_cfg_in_run();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
